// File: rtl/snake_if.sv
// Control and scan bus of the snake engine.
interface snake_if #(
  parameter int XW = 5,
  parameter int YW = 5,
  parameter int LW = 8
);
  logic          i_tick;
  logic [1:0]    i_dir;
  logic          i_wrap;
  logic          i_eat;
  logic [1:0]    o_head_dir;
  logic [XW-1:0] o_pos_x;
  logic [YW-1:0] o_pos_y;
  logic          o_pos_first;
  logic          o_pos_last;
  logic          o_pos_valid;
  logic [LW-1:0] o_length;
  logic          o_failure;
  logic          o_success;

  modport master (
    output i_tick, i_dir, i_wrap, i_eat,
    input  o_head_dir, o_pos_x, o_pos_y, o_pos_first, o_pos_last,
           o_pos_valid, o_length, o_failure, o_success
  );

  modport slave (
    input  i_tick, i_dir, i_wrap, i_eat,
    output o_head_dir, o_pos_x, o_pos_y, o_pos_first, o_pos_last,
           o_pos_valid, o_length, o_failure, o_success
  );
endinterface

// File: rtl/snake_engine.sv
// Snake game engine: the body is stored as a chain of move directions
// behind the head and rebuilt one segment per cycle by a cyclic scan.
module snake_engine #(
  parameter int W        = 20,
  parameter int H        = 20,
  parameter int MAX_LEN  = 220,
  parameter int INIT_LEN = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  snake_if.slave bus
);

  localparam int XW = $clog2(W + 2);
  localparam int YW = $clog2(H + 2);
  localparam int LW = $clog2(MAX_LEN);

  localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [XW-1:0] X_HI   = XW'(W);
  localparam logic [XW-1:0] X_WALL = XW'(W + 1);
  localparam logic [XW-1:0] X_INIT = XW'(W / 2);
  localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [YW-1:0] Y_HI   = YW'(H);
  localparam logic [YW-1:0] Y_WALL = YW'(H + 1);
  localparam logic [YW-1:0] Y_INIT = YW'(H / 2);
  localparam logic [LW-1:0] LAST_IDX = LW'(MAX_LEN - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN - 1);
  localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);
  localparam logic [LW-1:0] L_ZERO   = {LW{1'b0}};
  localparam logic [LW-1:0] L_ONE    = LW'(1);

  localparam logic [1:0] DIR_YP = 2'b00;
  localparam logic [1:0] DIR_YM = 2'b01;
  localparam logic [1:0] DIR_XP = 2'b10;
  localparam logic [1:0] DIR_XM = 2'b11;

  // The two directions on one axis differ only in bit 0.
  function automatic logic [1:0] dir_opposite(input logic [1:0] dir);
    return dir ^ 2'b01;
  endfunction

  // One x step along dir; in wrap mode stepping past an edge lands on the far interior edge.
  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] x, input logic [1:0] dir,
                                           input logic wrap);
    logic [XW-1:0] nx;
    case (dir)
      DIR_XP:  nx = (wrap && (x == X_HI))  ? X_ONE : x + X_ONE;
      DIR_XM:  nx = (wrap && (x == X_ONE)) ? X_HI  : x - X_ONE;
      default: nx = x;
    endcase
    return nx;
  endfunction

  // One y step along dir; same folding rule as step_x.
  function automatic logic [YW-1:0] step_y(input logic [YW-1:0] y, input logic [1:0] dir,
                                           input logic wrap);
    logic [YW-1:0] ny;
    case (dir)
      DIR_YP:  ny = (wrap && (y == Y_HI))  ? Y_ONE : y + Y_ONE;
      DIR_YM:  ny = (wrap && (y == Y_ONE)) ? Y_HI  : y - Y_ONE;
      default: ny = y;
    endcase
    return ny;
  endfunction

  logic [1:0]    dirs_r [MAX_LEN];
  logic [LW-1:0] pos_r, len_r;
  logic [XW-1:0] cur_x_r, head_x_r;
  logic [YW-1:0] cur_y_r, head_y_r;
  logic [1:0]    hd_r;
  logic          pend_r, fail_r, succ_r, first_r, last_r, valid_r;

  logic          frozen_s, scan_end_s, move_s, hit_s, wall_s, pend_nxt_s;
  logic [1:0]    dir_app_s, hd_nxt_s, seg_dir_s;
  logic [XW-1:0] head_x_nxt_s, cur_x_nxt_s;
  logic [YW-1:0] head_y_nxt_s, cur_y_nxt_s;
  logic [LW-1:0] pos_nxt_s, len_nxt_s;

  // Move decision, next head, growth, next scanned segment and game-over conditions.
  always_comb begin
    frozen_s     = fail_r | succ_r;
    scan_end_s   = (pos_r == LAST_IDX);
    move_s       = scan_end_s & (pend_r | bus.i_tick) & ~frozen_s;
    dir_app_s    = bus.i_dir;
    head_x_nxt_s = head_x_r;
    head_y_nxt_s = head_y_r;
    hd_nxt_s     = hd_r;
    pend_nxt_s   = pend_r;
    len_nxt_s    = len_r;
    pos_nxt_s    = pos_r;
    cur_x_nxt_s  = cur_x_r;
    cur_y_nxt_s  = cur_y_r;
    seg_dir_s    = dir_opposite(dirs_r[pos_r]);

    if (bus.i_dir == dir_opposite(hd_r)) begin
      dir_app_s = hd_r;
    end else begin
      dir_app_s = bus.i_dir;
    end

    if (move_s) begin
      head_x_nxt_s = step_x(head_x_r, dir_app_s, bus.i_wrap);
      head_y_nxt_s = step_y(head_y_r, dir_app_s, bus.i_wrap);
      hd_nxt_s     = dir_app_s;
      pend_nxt_s   = 1'b0;
    end else begin
      pend_nxt_s   = pend_r | (bus.i_tick & ~frozen_s);
    end

    if (bus.i_eat && !frozen_s && (len_r != LEN_MAX)) begin
      len_nxt_s = len_r + L_ONE;
    end else begin
      len_nxt_s = len_r;
    end

    if (scan_end_s) begin
      pos_nxt_s   = L_ZERO;
      cur_x_nxt_s = head_x_nxt_s;
      cur_y_nxt_s = head_y_nxt_s;
    end else begin
      pos_nxt_s   = pos_r + L_ONE;
      cur_x_nxt_s = step_x(cur_x_r, seg_dir_s, bus.i_wrap);
      cur_y_nxt_s = step_y(cur_y_r, seg_dir_s, bus.i_wrap);
    end

    hit_s  = valid_r & ~first_r & (cur_x_r == head_x_r) & (cur_y_r == head_y_r);
    wall_s = ~bus.i_wrap & ((head_x_r == X_ZERO) | (head_x_r == X_WALL) |
                            (head_y_r == Y_ZERO) | (head_y_r == Y_WALL));
  end

  // Direction store: the newest applied move enters at index 0, older moves shift back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) dirs_r[i] <= DIR_YP;
    end else if (move_s) begin
      dirs_r[0] <= dir_app_s;
      for (int i = 1; i < MAX_LEN; i++) dirs_r[i] <= dirs_r[i-1];
    end
  end

  // Head, scan position, length, pending tick, sticky flags and registered scan qualifiers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_r    <= LAST_IDX;
      len_r    <= LEN_INIT;
      head_x_r <= X_INIT;
      head_y_r <= Y_INIT;
      cur_x_r  <= X_INIT;
      cur_y_r  <= Y_INIT;
      hd_r     <= DIR_YP;
      pend_r   <= 1'b0;
      fail_r   <= 1'b0;
      succ_r   <= 1'b0;
      first_r  <= 1'b0;
      last_r   <= (LAST_IDX == LEN_INIT);
      valid_r  <= 1'b0;
    end else begin
      pos_r    <= pos_nxt_s;
      len_r    <= len_nxt_s;
      head_x_r <= head_x_nxt_s;
      head_y_r <= head_y_nxt_s;
      cur_x_r  <= cur_x_nxt_s;
      cur_y_r  <= cur_y_nxt_s;
      hd_r     <= hd_nxt_s;
      pend_r   <= pend_nxt_s;
      fail_r   <= fail_r | hit_s | wall_s;
      succ_r   <= succ_r | (len_r == LEN_MAX);
      first_r  <= (pos_nxt_s == L_ZERO);
      last_r   <= (pos_nxt_s == len_nxt_s);
      valid_r  <= (pos_nxt_s <= len_nxt_s);
    end
  end

  assign bus.o_head_dir  = hd_r;
  assign bus.o_pos_x     = cur_x_r;
  assign bus.o_pos_y     = cur_y_r;
  assign bus.o_pos_first = first_r;
  assign bus.o_pos_last  = last_r;
  assign bus.o_pos_valid = valid_r;
  assign bus.o_length    = len_r;
  assign bus.o_failure   = fail_r;
  assign bus.o_success   = succ_r;

endmodule

// File: tb/tb_snake_engine.sv
// Randomized bench for snake_engine: a default-size engine and an 8-slot engine
// run side by side against a reference model that keeps the body as a list of
// visited head positions.
module tb_snake_engine;

  localparam int NI  = 2;
  localparam int W0  = 20, H0 = 20, M0 = 220, I0 = 4;
  localparam int W1  = 6,  H1 = 6,  M1 = 8,   I1 = 4;
  localparam int XW0 = $clog2(W0 + 2), YW0 = $clog2(H0 + 2), LW0 = $clog2(M0);
  localparam int XW1 = $clog2(W1 + 2), YW1 = $clog2(H1 + 2), LW1 = $clog2(M1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snake_if #(.XW(XW0), .YW(YW0), .LW(LW0)) bus0 ();
  snake_if #(.XW(XW1), .YW(YW1), .LW(LW1)) bus1 ();

  snake_engine #(.W(W0), .H(H0), .MAX_LEN(M0), .INIT_LEN(I0)) u_big (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  snake_engine #(.W(W1), .H(H1), .MAX_LEN(M1), .INIT_LEN(I1)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int pw  [NI] = '{W0, W1};
  int ph  [NI] = '{H0, H1};
  int pm  [NI] = '{M0, M1};
  int pin [NI] = '{I0, I1};
  int pyw [NI] = '{YW0, YW1};

  // model: hx/hy[k] is the position of segment k (0 = head), i.e. past heads
  int hx [NI][M0];
  int hy [NI][M0];
  int m_pos [NI];
  int m_len [NI];
  int m_hd  [NI];
  bit m_pend [NI];
  bit m_fail [NI];
  bit m_succ [NI];
  bit m_wrap [NI];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic string tg(input int id, input string s);
    return $sformatf("u%0d_%s", id, s);
  endfunction

  // fold any integer onto 1..n (toroidal coordinate)
  function automatic int wrapc(input int v, input int n);
    return ((v - 1) % n + n) % n + 1;
  endfunction

  task automatic m_reset(input int id);
    int y;
    m_pos[id]  = pm[id] - 1;
    m_len[id]  = pin[id];
    m_hd[id]   = 0;
    m_pend[id] = 1'b0;
    m_fail[id] = 1'b0;
    m_succ[id] = 1'b0;
    for (int k = 0; k < pm[id]; k++) begin
      hx[id][k] = pw[id] / 2;
      y = ph[id] / 2 - k;
      hy[id][k] = m_wrap[id] ? wrapc(y, ph[id]) : (y & ((1 << pyw[id]) - 1));
    end
  endtask

  task automatic m_step(input int id, input logic rst, input logic tick,
                        input logic [1:0] dir, input logic eat, output bit moved);
    bit frozen, hit, wall, nfail, nsucc;
    int d, nx, ny, p;
    moved = 1'b0;
    if (!rst) begin
      m_reset(id);
    end else begin
      p      = m_pos[id];
      frozen = m_fail[id] || m_succ[id];
      hit    = (p >= 1) && (p <= m_len[id]) && (hx[id][p] == hx[id][0]) && (hy[id][p] == hy[id][0]);
      wall   = !m_wrap[id] && (hx[id][0] == 0 || hx[id][0] == pw[id] + 1 ||
                               hy[id][0] == 0 || hy[id][0] == ph[id] + 1);
      nfail  = m_fail[id] || hit || wall;
      nsucc  = m_succ[id] || (m_len[id] == pm[id] - 1);
      if (tick && !frozen) m_pend[id] = 1'b1;
      if (eat && !frozen && m_len[id] < pm[id] - 1) m_len[id]++;
      if (p == pm[id] - 1) begin
        if (m_pend[id] && !frozen) begin
          d = int'(dir);
          if ((d / 2 == m_hd[id] / 2) && (d != m_hd[id])) d = m_hd[id];
          nx = hx[id][0];
          ny = hy[id][0];
          case (d)
            0: ny = ny + 1;
            1: ny = ny - 1;
            2: nx = nx + 1;
            default: nx = nx - 1;
          endcase
          if (m_wrap[id]) begin
            nx = wrapc(nx, pw[id]);
            ny = wrapc(ny, ph[id]);
          end
          for (int k = pm[id] - 1; k > 0; k--) begin
            hx[id][k] = hx[id][k-1];
            hy[id][k] = hy[id][k-1];
          end
          hx[id][0]  = nx;
          hy[id][0]  = ny;
          m_hd[id]   = d;
          m_pend[id] = 1'b0;
          moved      = 1'b1;
        end
        m_pos[id] = 0;
      end else begin
        m_pos[id] = p + 1;
      end
      m_fail[id] = nfail;
      m_succ[id] = nsucc;
    end
  endtask

  task automatic m_check(input int id);
    logic [31:0] gx, gy, gf, gl, gv, gn, gd, gfa, gsu;
    if (id == 0) begin
      gx = 32'(bus0.o_pos_x);      gy = 32'(bus0.o_pos_y);
      gf = 32'(bus0.o_pos_first);  gl = 32'(bus0.o_pos_last);
      gv = 32'(bus0.o_pos_valid);  gn = 32'(bus0.o_length);
      gd = 32'(bus0.o_head_dir);   gfa = 32'(bus0.o_failure);
      gsu = 32'(bus0.o_success);
    end else begin
      gx = 32'(bus1.o_pos_x);      gy = 32'(bus1.o_pos_y);
      gf = 32'(bus1.o_pos_first);  gl = 32'(bus1.o_pos_last);
      gv = 32'(bus1.o_pos_valid);  gn = 32'(bus1.o_length);
      gd = 32'(bus1.o_head_dir);   gfa = 32'(bus1.o_failure);
      gsu = 32'(bus1.o_success);
    end
    check(tg(id, "valid"),   gv,  (m_pos[id] <= m_len[id]) ? 1 : 0);
    check(tg(id, "first"),   gf,  (m_pos[id] == 0) ? 1 : 0);
    check(tg(id, "last"),    gl,  (m_pos[id] == m_len[id]) ? 1 : 0);
    check(tg(id, "length"),  gn,  m_len[id]);
    check(tg(id, "headdir"), gd,  m_hd[id]);
    check(tg(id, "failure"), gfa, m_fail[id] ? 1 : 0);
    check(tg(id, "success"), gsu, m_succ[id] ? 1 : 0);
    if (m_pos[id] <= m_len[id]) begin
      check(tg(id, "pos_x"), gx, hx[id][m_pos[id]]);
      check(tg(id, "pos_y"), gy, hy[id][m_pos[id]]);
    end
  endtask

  initial begin
    logic [1:0] scr [$];
    logic       t_tick [NI];
    logic [1:0] t_dir  [NI];
    logic       t_eat  [NI];
    bit         w_new  [NI];
    bit         moved, started;
    int         ncyc, rst_cyc;

    started = 1'b0;
    bus0.i_tick = 1'b0; bus0.i_dir = 2'b00; bus0.i_wrap = 1'b0; bus0.i_eat = 1'b0;
    bus1.i_tick = 1'b0; bus1.i_dir = 2'b00; bus1.i_wrap = 1'b0; bus1.i_eat = 1'b0;

    for (int g = 0; g < 10; g++) begin
      // games 0..3 drive the big engine from a direction script
      scr.delete();
      case (g)
        0: begin w_new[0] = 1'b0; scr.push_back(2'b01); scr.push_back(2'b10); end
        1: begin w_new[0] = 1'b0; scr.push_back(2'b10); scr.push_back(2'b01); scr.push_back(2'b11); end
        2, 3: begin
          w_new[0] = (g == 3);
          for (int k = 0; k < 11; k++) scr.push_back(2'b10);
        end
        default: w_new[0] = 1'($urandom_range(0, 1));
      endcase
      w_new[1] = (g == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      ncyc     = (g < 4) ? (scr.size() + 3) * M0 : 4000;
      rst_cyc  = $urandom_range(1, 3);

      for (int c = 0; c < ncyc; c++) begin
        @(negedge clk);
        if (started) begin
          m_check(0);
          m_check(1);
        end
        if (c == 0) begin
          m_wrap[0] = w_new[0];
          m_wrap[1] = w_new[1];
          bus0.i_wrap = w_new[0];
          bus1.i_wrap = w_new[1];
        end
        rst_n = (c >= rst_cyc);

        if (g < 4) begin
          t_tick[0] = (scr.size() > 0) && (m_pos[0] == 50 || m_pos[0] == 100 || m_pos[0] == 150);
          t_dir[0]  = (scr.size() > 0) ? scr[0] : 2'b00;
          t_eat[0]  = (g == 1) && (c == 300);
        end else begin
          t_tick[0] = ($urandom_range(0, 59) == 0);
          t_dir[0]  = 2'($urandom_range(0, 3));
          t_eat[0]  = ($urandom_range(0, 249) == 0);
        end
        t_tick[1] = (g != 3) && ($urandom_range(0, 2) == 0);
        t_dir[1]  = 2'($urandom_range(0, 3));
        t_eat[1]  = ($urandom_range(0, 5) == 0);

        bus0.i_tick = t_tick[0]; bus0.i_dir = t_dir[0]; bus0.i_eat = t_eat[0];
        bus1.i_tick = t_tick[1]; bus1.i_dir = t_dir[1]; bus1.i_eat = t_eat[1];

        m_step(0, rst_n, t_tick[0], t_dir[0], t_eat[0], moved);
        if (moved && (scr.size() > 0)) void'(scr.pop_front());
        m_step(1, rst_n, t_tick[1], t_dir[1], t_eat[1], moved);
        started = 1'b1;
      end
    end

    @(negedge clk);
    m_check(0);
    m_check(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter W, default 20: playfield interior width; legal x range 1..W, walls at x=0 and x=W+1.
REQ-002 SHALL have parameter H, default 20: playfield interior height; legal y range 1..H, walls at y=0 and y=H+1.
REQ-003 SHALL have parameter MAX_LEN, default 220: scan period in cycles and direction-store depth; MAX_LEN >= INIT_LEN+2.
REQ-004 SHALL have parameter INIT_LEN, default 4: length after reset.
REQ-005 SHALL derive XW=$clog2(W+2), YW=$clog2(H+2), LW=$clog2(MAX_LEN).
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 i_tick  in  1  one-cycle move request; may arrive in any cycle.
REQ-009 i_dir  in  2  requested direction: 00 y+1, 01 y-1, 10 x+1, 11 x-1.
REQ-010 i_wrap  in  1  1 = toroidal playfield, 0 = walls are fatal; sampled at each move.
REQ-011 i_eat  in  1  one-cycle growth request.
REQ-012 o_head_dir  out  2  direction applied at the last move.
REQ-013 o_pos_x / o_pos_y  out  XW / YW  coordinate of the currently scanned segment.
REQ-014 o_pos_first / o_pos_last / o_pos_valid  out  1 each  scan index is 0 / equals length / is <= length.
REQ-015 o_length  out  LW  current length (segment count minus 1).
REQ-016 o_failure / o_success  out  1 each  sticky game-over flags.

Function
REQ-017 SHALL keep a scan index pos counting 0..MAX_LEN-1 and wrapping; each cycle presents segment pos (0 = head).
REQ-018 SHALL derive segment pos+1 from segment pos by stepping opposite to that segment's stored move direction; in wrap mode, the step wraps 1<->W and 1<->H.
REQ-019 SHALL latch i_tick into a pending flag; multiple ticks before the next move collapse into one move.
REQ-020 SHALL, in the cycle where pos==MAX_LEN-1 with tick pending and not frozen: update the head, push the applied direction to the front of the direction store, and clear the pending flag.
REQ-021 SHALL sample i_dir at the move cycle; a direction exactly opposite o_head_dir SHALL be replaced by o_head_dir (no reversal).
REQ-022 SHALL, in wrap mode, map head x W+1->1 and 0->W (likewise y with H); otherwise the head SHALL move onto the wall coordinate.
REQ-023 SHALL present the head as scan index 0 in the cycle after pos==MAX_LEN-1, new head if moved.
REQ-024 SHALL increment length by 1 per i_eat cycle, saturating at MAX_LEN-1; i_eat in a move cycle SHALL take effect on that same edge.
REQ-025 SHALL set o_failure on the edge after either condition: (valid, pos!=0, scanned coordinate == head) or (wrap off, head on a wall).
REQ-026 SHALL set o_success on the edge after length reaches MAX_LEN-1.
REQ-027 SHALL treat the block as frozen while o_failure or o_success is set: ticks and eats ignored, scanning continues.
REQ-028 SHALL drive o_pos_valid=0 for pos > length.

Reset
REQ-029 SHALL on rst_n=0 set head=(W/2,H/2), o_head_dir=00, all stored directions=00, length=INIT_LEN, pos=MAX_LEN-1, o_pos_valid=0, tick pending=0, o_failure=0, o_success=0.
REQ-030 SHALL give reset priority over every event, including a move cycle or pending tick, mid-scan.

Verification
REQ-031 Reset, defaults -> o_pos_valid=0 for 1 cycle, then (10,10),(10,9),(10,8),(10,7),(10,6), o_pos_last at pos 4, valid=0 for pos 5..219.
REQ-032 i_tick with i_dir=10 -> next scan head (11,10), segment 1 (10,10), o_head_dir=10; three ticks in one scan -> exactly one move.
REQ-033 o_head_dir=00, tick with i_dir=01 -> head (10,11), o_head_dir stays 00.
REQ-034 Head (20,y), dir 10, i_wrap=0 -> head x=21, o_failure=1 until reset; repeated with i_wrap=1 -> head x=1, no failure.
REQ-035 i_eat pulse -> o_length=5, six valid segments, o_pos_last at pos 5; body loop into own segment -> o_failure=1.
REQ-036 MAX_LEN=8: eat to length 7 -> o_success=1, further i_eat and i_tick ignored, o_length stays 7.
